// File: rtl/riscv_gpr_wb_arbiter.sv
// riscv_gpr_wb_arbiter
// Shares the single GPR write port between the ALU and the load/store unit.
// Each requester feeds a DEPTH-entry queue through a valid/ready handshake;
// every accepted entry is stamped from a global arrival counter, and one
// queue head per cycle is granted (oldest first) into a registered write
// port. A combinational scoreboard reports pending writes for two decode
// read addresses.
//
// Ports:
//   clk, rst_n                  core clock, async active-low reset
//   alu_wb_valid/ready/dest/data  ALU writeback handshake
//   lsu_wb_valid/ready/dest/data  load writeback handshake
//   reg_write_en/dest/data      registered GPR write port
//   busy_addr_a/b, busy_a/b     pending-write queries (rs1/rs2)
//
// Build option:
//   GPR_WB_PRIO_EN  when defined, LSU wins over ALU by fixed priority unless
//                   both heads target the same nonzero register (then the
//                   older head wins so per-register order holds).
module riscv_gpr_wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned SEQ_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_wb_valid,
    output logic        alu_wb_ready,
    input  logic [4:0]  alu_wb_dest,
    input  logic [31:0] alu_wb_data,
    input  logic        lsu_wb_valid,
    output logic        lsu_wb_ready,
    input  logic [4:0]  lsu_wb_dest,
    input  logic [31:0] lsu_wb_data,
    output logic        reg_write_en,
    output logic [4:0]  reg_write_dest,
    output logic [31:0] reg_write_data,
    input  logic [4:0]  busy_addr_a,
    output logic        busy_a,
    input  logic [4:0]  busy_addr_b,
    output logic        busy_b
);

    localparam int unsigned NQ    = 2;  // index 0 = LSU, 1 = ALU
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Queue storage and control
    logic [4:0]       q_dest  [NQ][DEPTH];
    logic [31:0]      q_data  [NQ][DEPTH];
    logic [SEQ_W-1:0] q_stamp [NQ][DEPTH];
    logic [PTR_W-1:0] rd_ptr  [NQ];
    logic [PTR_W-1:0] wr_ptr  [NQ];
    logic [CNT_W-1:0] count   [NQ];
    logic [SEQ_W-1:0] seq;
    logic             rdy_en;

    logic [NQ-1:0]    in_valid;
    logic [NQ-1:0]    ready_v;
    logic [NQ-1:0]    acc_v;
    logic [NQ-1:0]    head_v;
    logic [NQ-1:0]    grant_v;
    logic [4:0]       in_dest  [NQ];
    logic [31:0]      in_data  [NQ];
    logic [SEQ_W-1:0] stamp_in [NQ];
    logic [4:0]       hd_dest  [NQ];
    logic [31:0]      hd_data  [NQ];
    logic [SEQ_W-1:0] hd_stamp [NQ];
    logic             lsu_older;
    logic [4:0]       g_dest;
    logic [31:0]      g_data;
    logic             do_write;

    // x is older than y when y-x (mod 2^SEQ_W) is nonzero with a clear MSB
    function automatic logic is_older(input logic [SEQ_W-1:0] x,
                                      input logic [SEQ_W-1:0] y);
        logic [SEQ_W-1:0] diff;
        diff = y - x;
        return (diff != '0) && !diff[SEQ_W-1];
    endfunction

    assign in_valid   = {alu_wb_valid, lsu_wb_valid};
    assign in_dest[0] = lsu_wb_dest;
    assign in_dest[1] = alu_wb_dest;
    assign in_data[0] = lsu_wb_data;
    assign in_data[1] = alu_wb_data;

    // Same-cycle tie: LSU takes the lower stamp
    assign stamp_in[0] = seq;
    assign stamp_in[1] = seq + SEQ_W'(acc_v[0]);

    for (genvar q = 0; q < NQ; q++) begin : g_q
        // Ready is a function of registered state only; rdy_en holds it low
        // through reset and for the edge-free window right after release
        assign ready_v[q]  = rdy_en && (count[q] < CNT_W'(DEPTH));
        assign acc_v[q]    = in_valid[q] && ready_v[q];
        assign head_v[q]   = (count[q] != '0);
        assign hd_dest[q]  = q_dest[q][rd_ptr[q]];
        assign hd_data[q]  = q_data[q][rd_ptr[q]];
        assign hd_stamp[q] = q_stamp[q][rd_ptr[q]];
    end

    assign lsu_wb_ready = ready_v[0];
    assign alu_wb_ready = ready_v[1];
    assign lsu_older    = is_older(hd_stamp[0], hd_stamp[1]);

    // Head arbitration
    always_comb begin
        logic pick_lsu;
        pick_lsu = 1'b0;
        grant_v  = head_v;
        if (head_v[0] && head_v[1]) begin
`ifdef GPR_WB_PRIO_EN
            if ((hd_dest[0] == hd_dest[1]) && (hd_dest[0] != '0)) begin
                pick_lsu = lsu_older;
            end else begin
                pick_lsu = 1'b1;
            end
`else
            pick_lsu = lsu_older;
`endif
            grant_v = {!pick_lsu, pick_lsu};
        end
    end

    assign g_dest   = grant_v[0] ? hd_dest[0] : hd_dest[1];
    assign g_data   = grant_v[0] ? hd_data[0] : hd_data[1];
    assign do_write = (|grant_v) && (g_dest != '0);

    // Queue payload storage (validity tracked by pointers/count)
    always_ff @(posedge clk) begin
        for (int unsigned q = 0; q < NQ; q++) begin
            if (acc_v[q]) begin
                q_dest[q][wr_ptr[q]]  <= in_dest[q];
                q_data[q][wr_ptr[q]]  <= in_data[q];
                q_stamp[q][wr_ptr[q]] <= stamp_in[q];
            end
        end
    end

    // Queue pointers, counts and the arrival counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
            seq    <= '0;
            for (int unsigned q = 0; q < NQ; q++) begin
                rd_ptr[q] <= '0;
                wr_ptr[q] <= '0;
                count[q]  <= '0;
            end
        end else begin
            rdy_en <= 1'b1;
            seq    <= seq + SEQ_W'(acc_v[0]) + SEQ_W'(acc_v[1]);
            for (int unsigned q = 0; q < NQ; q++) begin
                if (acc_v[q])   wr_ptr[q] <= wr_ptr[q] + PTR_W'(1);
                if (grant_v[q]) rd_ptr[q] <= rd_ptr[q] + PTR_W'(1);
                count[q] <= count[q] + CNT_W'(acc_v[q]) - CNT_W'(grant_v[q]);
            end
        end
    end

    // Registered write port; dest/data hold when no write is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            reg_write_en <= do_write;
            if (do_write) begin
                reg_write_dest <= g_dest;
                reg_write_data <= g_data;
            end
        end
    end

    // Pending-write scoreboard over live queue entries and the output stage
    always_comb begin
        logic [PTR_W-1:0] off;
        logic             hit_a;
        logic             hit_b;
        off   = '0;
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int unsigned q = 0; q < NQ; q++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                off = PTR_W'(i) - rd_ptr[q];
                if (CNT_W'(off) < count[q]) begin
                    if (q_dest[q][i] == busy_addr_a) hit_a = 1'b1;
                    if (q_dest[q][i] == busy_addr_b) hit_b = 1'b1;
                end
            end
        end
        if (reg_write_en && (reg_write_dest == busy_addr_a)) hit_a = 1'b1;
        if (reg_write_en && (reg_write_dest == busy_addr_b)) hit_b = 1'b1;
        busy_a = hit_a && (busy_addr_a != '0);
        busy_b = hit_b && (busy_addr_b != '0);
    end

endmodule

// File: tb/tb_riscv_gpr_wb_arbiter.sv
// Self-checking bench for riscv_gpr_wb_arbiter: directed scenarios plus a
// long random run checked against a queue of expected writes.
module tb_riscv_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_wb_valid = 1'b0, lsu_wb_valid = 1'b0;
    logic        alu_wb_ready, lsu_wb_ready;
    logic [4:0]  alu_wb_dest = '0, lsu_wb_dest = '0;
    logic [31:0] alu_wb_data = '0, lsu_wb_data = '0;
    logic        reg_write_en;
    logic [4:0]  reg_write_dest;
    logic [31:0] reg_write_data;
    logic [4:0]  busy_addr_a = '0, busy_addr_b = '0;
    logic        busy_a, busy_b;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  tests_run = 0;
    int  fails = 0;
    int  last_acc = 0;

    riscv_gpr_wb_arbiter #(.DEPTH(2), .SEQ_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
        .alu_wb_dest(alu_wb_dest), .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_dest(lsu_wb_dest), .lsu_wb_data(lsu_wb_data),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data),
        .busy_addr_a(busy_addr_a), .busy_a(busy_a),
        .busy_addr_b(busy_addr_b), .busy_b(busy_b)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Advance one edge; record accepted nonzero-dest entries (LSU first)
    task automatic tick();
        logic al, aa;
        al = lsu_wb_valid && lsu_wb_ready;
        aa = alu_wb_valid && alu_wb_ready;
        @(posedge clk);
        #1;
        if (al && lsu_wb_dest != 5'd0) exp_q.push_back('{dest: lsu_wb_dest, data: lsu_wb_data});
        if (aa && alu_wb_dest != 5'd0) exp_q.push_back('{dest: alu_wb_dest, data: alu_wb_data});
        last_acc = int'(al) + int'(aa);
    endtask

    task automatic idle();
        alu_wb_valid = 1'b0;
        lsu_wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        busy_addr_a = 5'd5;
        busy_addr_b = 5'd7;
        #12;
        tests_run++;
        if (reg_write_en !== 1'b0 || reg_write_dest !== 5'd0 || reg_write_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs got en=%b dest=%0d data=%h want 0/0/0",
                     reg_write_en, reg_write_dest, reg_write_data);
        end
        tests_run++;
        if (alu_wb_ready !== 1'b0 || lsu_wb_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready got alu=%b lsu=%b want 0/0", alu_wb_ready, lsu_wb_ready);
        end
        tests_run++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got a=%b b=%b want 0/0", busy_a, busy_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (alu_wb_ready !== 1'b1 || lsu_wb_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_ready got alu=%b lsu=%b want 1/1", alu_wb_ready, lsu_wb_ready);
        end
        exp_q.delete();
    endtask

    task automatic test_single();
        busy_addr_a = 5'd5;
        alu_wb_valid = 1'b1;
        alu_wb_dest = 5'd5;
        alu_wb_data = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (busy_a !== 1'b0) begin
            fails++;
            $display("FAIL single_busy_pre got %b want 0", busy_a);
        end
        tick();
        idle();
        tests_run++;
        if (reg_write_en !== 1'b0 || busy_a !== 1'b1) begin
            fails++;
            $display("FAIL single_queued got en=%b busy=%b want 0/1", reg_write_en, busy_a);
        end
        tick();
        tests_run++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd5 || reg_write_data !== 32'hDEADBEEF || busy_a !== 1'b1) begin
            fails++;
            $display("FAIL single_write got en=%b dest=%0d data=%h busy=%b want 1/5/deadbeef/1",
                     reg_write_en, reg_write_dest, reg_write_data, busy_a);
        end
        tick();
        tests_run++;
        if (reg_write_en !== 1'b0 || busy_a !== 1'b0 || reg_write_dest !== 5'd5) begin
            fails++;
            $display("FAIL single_after got en=%b busy=%b dest=%0d want 0/0/5",
                     reg_write_en, busy_a, reg_write_dest);
        end
        exp_q.delete();
    endtask

    task automatic test_same_cycle();
        lsu_wb_valid = 1'b1; lsu_wb_dest = 5'd7; lsu_wb_data = 32'd1;
        alu_wb_valid = 1'b1; alu_wb_dest = 5'd7; alu_wb_data = 32'd2;
        tick();
        idle();
        tests_run++;
        if (reg_write_en !== 1'b0) begin
            fails++;
            $display("FAIL tie_lat got en=%b want 0", reg_write_en);
        end
        tick();
        tests_run++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd7 || reg_write_data !== 32'd1) begin
            fails++;
            $display("FAIL tie_first got en=%b dest=%0d data=%h want 1/7/1",
                     reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
        tests_run++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 5'd7 || reg_write_data !== 32'd2) begin
            fails++;
            $display("FAIL tie_second got en=%b dest=%0d data=%h want 1/7/2",
                     reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
        tests_run++;
        if (reg_write_en !== 1'b0 || reg_write_data !== 32'd2) begin
            fails++;
            $display("FAIL tie_final got en=%b data=%h want 0/2", reg_write_en, reg_write_data);
        end
        exp_q.delete();
    endtask

    task automatic test_fill_alu();
        bit seen_back;
        int idx;
        bit ordered_ok;
        seen_back = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 30; c++) begin
            idle();
            if (c < 2) begin
                alu_wb_valid = 1'b1; alu_wb_dest = 5'(20 + c); alu_wb_data = 32'(256 + c);
            end
            if (c < 5) begin
                lsu_wb_valid = 1'b1; lsu_wb_dest = 5'(10 + c); lsu_wb_data = 32'(c);
            end
            tick();
            if (c == 1) begin
                tests_run++;
                if (alu_wb_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL fill_full got alu_ready=%b want 0", alu_wb_ready);
                end
            end
            if (c >= 2 && alu_wb_ready === 1'b1) seen_back = 1'b1;
            if (reg_write_en === 1'b1) begin
                idx = -1;
                for (int j = 0; j < exp_q.size(); j++)
                    if (idx < 0 && exp_q[j].dest == reg_write_dest) idx = j;
                tests_run++;
                if (idx < 0) begin
                    fails++;
                    $display("FAIL fill_write unexpected dest=%0d data=%h", reg_write_dest, reg_write_data);
                end else begin
`ifdef GPR_WB_PRIO_EN
                    ordered_ok = 1'b1;
`else
                    ordered_ok = (idx == 0);
`endif
                    if (!ordered_ok || exp_q[idx].data !== reg_write_data) begin
                        fails++;
                        $display("FAIL fill_write got dest=%0d data=%h want dest=%0d data=%h",
                                 reg_write_dest, reg_write_data, exp_q[0].dest, exp_q[0].data);
                    end
                    exp_q.delete(idx);
                end
            end
        end
        tests_run++;
        if (seen_back !== 1'b1) begin
            fails++;
            $display("FAIL fill_ready_back got never-ready want ready=1");
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL fill_drain got %0d pending want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_x0();
        busy_addr_a = 5'd0;
        alu_wb_valid = 1'b1; alu_wb_dest = 5'd0; alu_wb_data = 32'h1234;
        tick();
        idle();
        tests_run++;
        if (last_acc != 1 || busy_a !== 1'b0 || reg_write_en !== 1'b0) begin
            fails++;
            $display("FAIL x0_accept got acc=%0d busy=%b en=%b want 1/0/0", last_acc, busy_a, reg_write_en);
        end
        tick();
        tests_run++;
        if (reg_write_en !== 1'b0) begin
            fails++;
            $display("FAIL x0_nowrite got en=%b want 0", reg_write_en);
        end
        tick();
        tests_run++;
        if (reg_write_en !== 1'b0 || alu_wb_ready !== 1'b1) begin
            fails++;
            $display("FAIL x0_drained got en=%b ready=%b want 0/1", reg_write_en, alu_wb_ready);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        lsu_wb_valid = 1'b1; lsu_wb_dest = 5'd9;  lsu_wb_data = 32'h99;
        alu_wb_valid = 1'b1; alu_wb_dest = 5'd10; alu_wb_data = 32'hA0;
        tick();
        lsu_wb_dest = 5'd11; lsu_wb_data = 32'hB0;
        alu_wb_dest = 5'd12; alu_wb_data = 32'hC0;
        tick();
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (reg_write_en !== 1'b0 || alu_wb_ready !== 1'b0 || lsu_wb_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async got en=%b ready=%b/%b want 0/0/0",
                     reg_write_en, alu_wb_ready, lsu_wb_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (reg_write_en !== 1'b0) begin
                fails++;
                $display("FAIL midrst_hold got en=%b want 0", reg_write_en);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (reg_write_en !== 1'b0 || alu_wb_ready !== 1'b1 || lsu_wb_ready !== 1'b1) begin
                fails++;
                $display("FAIL midrst_after got en=%b ready=%b/%b want 0/1/1",
                         reg_write_en, alu_wb_ready, lsu_wb_ready);
            end
        end
        for (int a = 0; a < 32; a++) begin
            busy_addr_a = 5'(a);
            busy_addr_b = 5'(31 - a);
            #1;
            tests_run++;
            if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
                fails++;
                $display("FAIL midrst_busy addr=%0d got a=%b b=%b want 0/0", a, busy_a, busy_b);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        int occ;
        bit grant_exp;
        bit exp_ba, exp_bb;
        int idx;
        bit ordered_ok;
        occ = 0;
        exp_q.delete();
        for (int c = 0; c < 1030; c++) begin
            idle();
            if (c < 1000) begin
                lsu_wb_valid = ($urandom % 4) != 0;
                lsu_wb_dest  = 5'($urandom_range(1, 31));
                lsu_wb_data  = $urandom;
                alu_wb_valid = ($urandom % 4) != 0;
                alu_wb_dest  = 5'($urandom_range(1, 31));
                alu_wb_data  = $urandom;
            end
            busy_addr_a = 5'($urandom_range(0, 31));
            busy_addr_b = 5'($urandom_range(1, 31));
            grant_exp = (occ > 0);
            tick();
            occ = occ - int'(grant_exp) + last_acc;
            tests_run++;
            if (reg_write_en !== grant_exp) begin
                fails++;
                $display("FAIL rand_rate cyc=%0d got en=%b want %b", c, reg_write_en, grant_exp);
            end
            exp_ba = 1'b0;
            exp_bb = 1'b0;
            foreach (exp_q[j]) begin
                if (exp_q[j].dest == busy_addr_a && busy_addr_a != 5'd0) exp_ba = 1'b1;
                if (exp_q[j].dest == busy_addr_b && busy_addr_b != 5'd0) exp_bb = 1'b1;
            end
            tests_run++;
            if (busy_a !== exp_ba || busy_b !== exp_bb) begin
                fails++;
                $display("FAIL rand_busy cyc=%0d got a=%b b=%b want %b/%b", c, busy_a, busy_b, exp_ba, exp_bb);
            end
            if (reg_write_en === 1'b1) begin
                idx = -1;
                for (int j = 0; j < exp_q.size(); j++)
                    if (idx < 0 && exp_q[j].dest == reg_write_dest) idx = j;
                tests_run++;
                if (idx < 0) begin
                    fails++;
                    $display("FAIL rand_write cyc=%0d unexpected dest=%0d data=%h", c, reg_write_dest, reg_write_data);
                end else begin
`ifdef GPR_WB_PRIO_EN
                    ordered_ok = 1'b1;
`else
                    ordered_ok = (idx == 0);
`endif
                    if (!ordered_ok || exp_q[idx].data !== reg_write_data) begin
                        fails++;
                        $display("FAIL rand_write cyc=%0d got dest=%0d data=%h want dest=%0d data=%h",
                                 c, reg_write_dest, reg_write_data, exp_q[0].dest, exp_q[0].data);
                    end
                    exp_q.delete(idx);
                end
            end
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rand_drain got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle();
        test_fill_alu();
        test_x0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
